// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

    // Register-file address width of rs/rt fields.
    localparam int REG_AW = 5;

    // Width of the MDU occupancy down-counter; covers MDU_LAT up to 255.
    localparam int MDU_CW = 8;

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_e;

    // One cycle's worth of pipeline register controls.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_t;

    // Whole pipe frozen (reset or external memory wait).
    localparam ctrl_t CTRL_IDLE = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0, exmem_write: 1'b0,
        memwb_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Everything advances, no bubbles.
    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
        memwb_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Taken branch: advance everything but kill the three younger stages.
    localparam ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
        memwb_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1
    };

    // MDU holds EX: freeze front end, send a bubble into EX/MEM, drain MEM/WB.
    localparam ctrl_t CTRL_MDU = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0, exmem_write: 1'b1,
        memwb_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b1
    };

    // Load-use: hold PC and IF/ID, insert a bubble into ID/EX.
    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1, exmem_write: 1'b1,
        memwb_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational load-use hazard compare between ID/EX load and IF/ID sources.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    output logic              lu_hazard
);

    logic rs_match;
    logic rt_match;

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    always_comb begin
        rs_match  = (idex_rt == ifid_rs);
        rt_match  = ifid_uses_rt && (idex_rt == ifid_rt);
        lu_hazard = idex_mem_read && (idex_rt != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and stall sequencer: PC / pipe-register enables and flushes,
// MDU occupancy FSM and saturating stall/flush event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              idex_mem_read_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic              idex_mdu_start_i,
    input  logic              exmem_branch_taken_i,
    input  logic              ext_stall_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_write_o,
    output logic              exmem_write_o,
    output logic              memwb_write_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              exmem_flush_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // A single-cycle MDU never stalls the front end.
    localparam bit MDU_STALLS = (MDU_LAT > 1);

    // The start cycle is spent in RUN, so the wait counter covers the remaining
    // N-2 stall cycles and releases when it reaches zero.
    localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_STALLS ? MDU_LAT - 2 : 0);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [MDU_CW-1:0] mdu_cnt_q, mdu_cnt_d;
    ctrl_t             ctrl;
    logic              lu_hazard;
    logic              stall_ev;
    logic              flush_ev;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read_i),
        .idex_rt       (idex_rt_i),
        .ifid_rs       (ifid_rs_i),
        .ifid_rt       (ifid_rt_i),
        .ifid_uses_rt  (ifid_uses_rt_i),
        .lu_hazard     (lu_hazard)
    );

    // Priority mux (reset, ext stall, branch, MDU, load-use) and FSM next state.
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        flush_ev  = 1'b0;
        if (!rst_i && !ext_stall_i) begin
            if (exmem_branch_taken_i) begin
                // Branch also cancels any MDU wait; the MDU op is on the wrong path.
                ctrl      = CTRL_BRANCH;
                state_d   = RUN;
                mdu_cnt_d = '0;
                flush_ev  = 1'b1;
            end else if (state_q == MDU_WAIT) begin
                if (mdu_cnt_q == '0) begin
                    ctrl    = CTRL_RUN;
                    state_d = RUN;
                end else begin
                    ctrl      = CTRL_MDU;
                    mdu_cnt_d = mdu_cnt_q - MDU_CW'(1);
                end
            end else if (idex_mdu_start_i && MDU_STALLS) begin
                ctrl      = CTRL_MDU;
                state_d   = MDU_WAIT;
                mdu_cnt_d = MDU_LOAD;
            end else if (lu_hazard) begin
                ctrl = CTRL_LOAD_USE;
            end else begin
                ctrl = CTRL_RUN;
            end
        end
    end

    // Reset and ext stall also zero pc_write, but neither counts as a stall event.
    always_comb begin
        stall_ev = !rst_i && !ext_stall_i && !ctrl.pc_write;
    end

    // FSM state and MDU occupancy counter; ext stall freezes both via the mux.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            mdu_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_ev && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if (flush_ev && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end
        end
    end

    // Drive the control outputs straight from the selected control word.
    always_comb begin
        pc_write_o    = ctrl.pc_write;
        ifid_write_o  = ctrl.ifid_write;
        idex_write_o  = ctrl.idex_write;
        exmem_write_o = ctrl.exmem_write;
        memwb_write_o = ctrl.memwb_write;
        ifid_flush_o  = ctrl.ifid_flush;
        idex_flush_o  = ctrl.idex_flush;
        exmem_flush_o = ctrl.exmem_flush;
        busy_o        = !rst_i && (state_q == MDU_WAIT);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: elapsed-cycle behavioural model compared
// every negedge against two DUTs (16-bit and 4-bit counters) plus directed literals.
module tb_pipe_ctrl;

    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 1'b0;
    logic [4:0] idex_rt = '0;
    logic [4:0] ifid_rs = '0;
    logic [4:0] ifid_rt = '0;
    logic       uses_rt = 1'b0;
    logic       start = 1'b0;
    logic       br = 1'b0;
    logic       ext = 1'b0;

    // writes {pc, ifid, idex, exmem, memwb}; flushes {ifid, idex, exmem}
    logic [4:0]  w1, w4;
    logic [2:0]  f1, f4;
    logic        b1, b4;
    logic [15:0] sc1, fc1;
    logic [3:0]  sc4, fc4;

    int tests = 0;
    int fails = 0;

    // Model state: cycles elapsed since an MDU op started (0 = none in flight).
    int phase   = 0;
    int stall_n = 0;
    int flush_n = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MDU_LAT(LAT), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .idex_mem_read_i(mem_read), .idex_rt_i(idex_rt),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt),
        .idex_mdu_start_i(start), .exmem_branch_taken_i(br), .ext_stall_i(ext),
        .pc_write_o(w1[4]), .ifid_write_o(w1[3]), .idex_write_o(w1[2]),
        .exmem_write_o(w1[1]), .memwb_write_o(w1[0]), .ifid_flush_o(f1[2]),
        .idex_flush_o(f1[1]), .exmem_flush_o(f1[0]), .busy_o(b1),
        .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    pipe_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .idex_mem_read_i(mem_read), .idex_rt_i(idex_rt),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt),
        .idex_mdu_start_i(start), .exmem_branch_taken_i(br), .ext_stall_i(ext),
        .pc_write_o(w4[4]), .ifid_write_o(w4[3]), .idex_write_o(w4[2]),
        .exmem_write_o(w4[1]), .memwb_write_o(w4[0]), .ifid_flush_o(f4[2]),
        .idex_flush_o(f4[1]), .exmem_flush_o(f4[0]), .busy_o(b4),
        .stall_cnt_o(sc4), .flush_cnt_o(fc4)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int width);
        int mx;
        mx = (1 << width) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic lu_model();
        return mem_read && (idex_rt != 0) &&
               ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));
    endfunction

    // Returns {writes[4:0], flushes[2:0], busy} required for the current cycle.
    function automatic logic [8:0] model_out();
        logic [4:0] w;
        logic [2:0] f;
        w = 5'b00000;
        f = 3'b000;
        if (rst || ext) begin
            w = 5'b00000;
        end else if (br) begin
            w = 5'b11111;
            f = 3'b111;
        end else if (phase >= 1) begin
            if (phase == LAT - 1) begin
                w = 5'b11111;
            end else begin
                w = 5'b00011;
                f = 3'b001;
            end
        end else if (start) begin
            w = 5'b00011;
            f = 3'b001;
        end else if (lu_model()) begin
            w = 5'b00111;
            f = 3'b010;
        end else begin
            w = 5'b11111;
        end
        return {w, f, (!rst && phase >= 1)};
    endfunction

    // Model advance on each clock edge; async reset clears it immediately.
    always @(posedge clk or posedge rst) begin : model_upd
        logic [8:0] e;
        if (rst) begin
            phase   <= 0;
            stall_n <= 0;
            flush_n <= 0;
        end else begin
            e = model_out();
            if (!ext && !e[8]) stall_n <= stall_n + 1;
            if (!ext) begin
                if (br) begin
                    phase   <= 0;
                    flush_n <= flush_n + 1;
                end else if (phase >= 1) begin
                    phase <= (phase == LAT - 1) ? 0 : phase + 1;
                end else if (start) begin
                    phase <= 1;
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin : cmp
        logic [8:0] e;
        e = model_out();
        check("writes", {27'd0, w1}, {27'd0, e[8:4]});
        check("flushes", {29'd0, f1}, {29'd0, e[3:1]});
        check("busy", {31'd0, b1}, {31'd0, e[0]});
        check("stall_cnt", {16'd0, sc1}, sat(stall_n, 16));
        check("flush_cnt", {16'd0, fc1}, sat(flush_n, 16));
        check("writes_w4", {27'd0, w4}, {27'd0, e[8:4]});
        check("flushes_w4", {29'd0, f4}, {29'd0, e[3:1]});
        check("busy_w4", {31'd0, b4}, {31'd0, e[0]});
        check("stall_cnt_w4", {28'd0, sc4}, sat(stall_n, 4));
        check("flush_cnt_w4", {28'd0, fc4}, sat(flush_n, 4));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        mem_read = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        uses_rt = 1'b0; start = 1'b0; br = 1'b0; ext = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : stim
        int n_pc0;
        int n_busy;
        logic [4:0] last_w;
        logic done;

        do_reset();
        check("reset_stall_cnt", {16'd0, sc1}, 32'd0);

        // Load r5 followed by a consumer of rs=5: one-cycle stall.
        mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        sample();
        check("lu_pc_write", {31'd0, w1[4]}, 32'd0);
        check("lu_ifid_write", {31'd0, w1[3]}, 32'd0);
        check("lu_idex_flush", {31'd0, f1[1]}, 32'd1);
        tick();
        mem_read = 1'b0;
        sample();
        check("lu_release_pc", {31'd0, w1[4]}, 32'd1);
        check("lu_stall_cnt", {16'd0, sc1}, 32'd1);
        tick();
        // Load into r0 never stalls.
        mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        sample();
        check("lu_r0_pc", {31'd0, w1[4]}, 32'd1);
        tick();
        // rt dependency only counts when rt is read.
        idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; uses_rt = 1'b1;
        sample();
        check("lu_rt_pc", {31'd0, w1[4]}, 32'd0);
        tick();
        uses_rt = 1'b0;
        sample();
        check("lu_rt_unused_pc", {31'd0, w1[4]}, 32'd1);
        tick();

        // MDU with start held: 7 stall cycles, 6 of them busy, release on 8th.
        do_reset();
        start = 1'b1;
        n_pc0 = 0; n_busy = 0; last_w = '0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (i < 7) begin
                if (!w1[4]) n_pc0++;
                if (b1) n_busy++;
            end else begin
                last_w = w1;
            end
            tick();
        end
        start = 1'b0;
        check("mdu_stall_cycles", n_pc0, 32'd7);
        check("mdu_busy_cycles", n_busy, 32'd6);
        check("mdu_release_writes", {27'd0, last_w}, 32'h1f);
        check("mdu_stall_cnt", {16'd0, sc1}, 32'd7);

        // Branch on cycle 3 of an MDU wait cancels it.
        do_reset();
        start = 1'b1;
        tick();
        tick();
        br = 1'b1;
        sample();
        check("br_flushes", {29'd0, f1}, 32'd7);
        tick();
        br = 1'b0; start = 1'b0;
        sample();
        check("br_busy_after", {31'd0, b1}, 32'd0);
        check("br_pc_after", {31'd0, w1[4]}, 32'd1);
        check("br_flush_cnt", {16'd0, fc1}, 32'd1);
        // Branch and MDU start together: branch wins, no wait.
        start = 1'b1; br = 1'b1;
        tick();
        start = 1'b0; br = 1'b0;
        sample();
        check("br_mdu_busy", {31'd0, b1}, 32'd0);
        check("br_mdu_flush_cnt", {16'd0, fc1}, 32'd2);
        tick();

        // Two ext stall cycles inside the wait stretch it to 9 frozen cycles.
        do_reset();
        start = 1'b1;
        n_pc0 = 0; done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            ext = (c == 3) || (c == 4);
            sample();
            if (w1[4]) done = 1'b1;
            else n_pc0++;
            tick();
        end
        start = 1'b0; ext = 1'b0;
        check("ext_release_seen", {31'd0, done}, 32'd1);
        check("ext_frozen_cycles", n_pc0, 32'd9);
        check("ext_stall_cnt", {16'd0, sc1}, 32'd7);

        // 20 load-use stalls: the 4-bit counter saturates.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            mem_read = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
            tick();
            mem_read = 1'b0;
            tick();
        end
        clear_in();
        check("sat_stall_cnt16", {16'd0, sc1}, 32'd20);
        check("sat_stall_cnt4", {28'd0, sc4}, 32'd15);

        // Asynchronous reset mid-wait, off the clock edge.
        do_reset();
        start = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc_write", {31'd0, w1[4]}, 32'd0);
        check("arst_memwb_write", {31'd0, w1[0]}, 32'd0);
        check("arst_busy", {31'd0, b1}, 32'd0);
        start = 1'b0;
        #3;
        rst = 1'b0;
        tick();
        check("arst_busy_after", {31'd0, b1}, 32'd0);
        check("arst_pc_after", {31'd0, w1[4]}, 32'd1);
        check("arst_stall_cnt", {16'd0, sc1}, 32'd0);
        check("arst_flush_cnt", {16'd0, fc1}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
